branch_seq: RTL and testbench
=============================

// Module: branch_seq
// PURPOSE
//   Multicycle branch sequencer for the RV32I core. Accepts one instruction from fetch and decodes
//   B-type fields (rs1, rs2, 13-bit immediate). Reads both operands over the register-file
//   handshake, evaluates the branch condition, and issues a one-cycle PC update to the PC register.
//   Non-branch opcodes are rejected with an error pulse; PC is left untouched.
// PARAMETERS
//   RF_TIMEOUT  15  max cycles waiting for rf_ack in READ before abort (>=1)
//   PC_STEP     4   fall-through increment added to pc when not taken
// PORTS
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   instr_valid  in   1   fetch offers instruction/pc
//   instr_ready  out  1   sequencer can accept (high only in IDLE)
//   instruction  in   32  raw instruction word
//   pc           in   32  address of instruction
//   rf_req       out  1   register-file read request
//   rf_a1        out  5   rs1 address = instruction[19:15]
//   rf_a2        out  5   rs2 address = instruction[24:20]
//   rf_ack       in   1   rf_rd1/rf_rd2 valid this cycle
//   rf_rd1       in   32  rs1 data
//   rf_rd2       in   32  rs2 data
//   pc_we        out  1   one-cycle PC write strobe
//   pc_next      out  32  next PC, valid while pc_we
//   taken        out  1   branch taken, valid while pc_we
//   err          out  1   one-cycle pulse: illegal opcode/func3 or RF timeout
// BEHAVIOUR
//   - Reset: state=IDLE; rf_req, pc_we, taken, err=0; pc_next, rf_a1, rf_a2=0; timeout counter=0.
//     Reset mid-operation aborts the transaction with no pc_we.
//   - States: IDLE -> READ -> EXEC -> DONE -> IDLE; ERR is a one-cycle state -> IDLE.
//   - IDLE: instr_ready=1. When instr_valid&&instr_ready, register instruction and pc.
//     - opcode==7'b1100011 and func3 supported -> READ.
//     - otherwise -> ERR.
//   - READ: rf_req=1. rf_a1/rf_a2 are held stable from registered fields.
//     - On rf_ack: capture rd1/rd2 -> EXEC.
//     - Counter increments each READ cycle without ack. When count==RF_TIMEOUT with no ack -> ERR.
//     - rf_ack in the same cycle as the limit wins (-> EXEC).
//   - EXEC: imm = sign-extend {i[31],i[7],i[30:25],i[11:8],1'b0} to 32 bits.
//     - target = pc+imm, mod 2^32 wrap.
//     - fall = pc+PC_STEP, mod 2^32 wrap.
//     - cond: BEQ(000) rd1==rd2; BNE(001) rd1!=rd2.
//     - Register taken=cond and pc_next=cond?target:fall.
//   - DONE: pc_we=1 for exactly one cycle; taken/pc_next valid -> IDLE.
//   - ERR: err=1 for one cycle, pc_we=0 -> IDLE.
//   - Latency: accept at cycle 0, READ at 1, ack at cycle k>=1, EXEC at k+1, pc_we at k+2.
//     With zero-wait RF, pc_we arrives at cycle 3.
//   - rf_ack outside READ is ignored. instr_valid outside IDLE is ignored (instr_ready=0).
//   - Outputs pc_next/taken hold their last value after DONE until the next EXEC.
// CONFIGURATION
//   BRANCH_EXT_EN defined: also accepts BLT(100)/BGE(101) (signed) and BLTU(110)/BGEU(111) (unsigned).
//   BRANCH_EXT_EN undefined: only BEQ/BNE are accepted; func3 010, 011 and 1xx -> ERR.
//   func3 010/011 -> ERR in both configurations.
// STRUCTURE
//   branch_pkg:
//     - OPC_BRANCH = 7'b1100011
//     - F3_BEQ/BNE/BLT/BGE/BLTU/BGEU constants
//     - state_t enum {IDLE, READ, EXEC, DONE, ERR}
//     - function b_imm(instr) returning the 32-bit sign-extended immediate
//   Sub-module b_target_gen (combinational): pc, instr, rd1, rd2 -> cond, target, fall.
//   The FSM, timeout counter and handshake stay in branch_seq.
// TESTING
//   - BEQ x1,x2,+8; pc=0x100, rd1=rd2=5, ack next cycle
//     -> pc_we at cycle 3, taken=1, pc_next=0x108.
//   - BNE imm=-4; pc=0x200, rd1=rd2=7 -> taken=0, pc_next=0x204.
//     Same instruction with rd1=7, rd2=8 -> pc_next=0x1FC.
//   - Opcode 0110011 offered -> err pulse at cycle 1, no rf_req, no pc_we, instr_ready=1 at cycle 2.
//   - BEQ with rf_ack never asserted, RF_TIMEOUT=15 -> rf_req held 15 cycles, then err pulse, no pc_we.
//     Ack at exactly the 15th cycle -> completes normally.
//   - BLT with rd1=0xFFFFFFFF, rd2=1:
//     - BRANCH_EXT_EN defined: taken=1.
//     - BLTU, same operands: taken=0.
//     - BRANCH_EXT_EN undefined: err pulse.
//   - rst asserted during READ -> immediate IDLE, rf_req=0, no pc_we.
//     Next instruction after release completes normally.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the RV32I branch sequencer.
// Optional BLT/BGE/BLTU/BGEU support is enabled by defining BRANCH_EXT_EN.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    DONE,
    ERR
  } state_t;

  // B-type immediate: scattered fields, bit 0 implicitly zero, sign from bit 31.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/b_target_gen.sv
// Combinational branch evaluation: condition, taken target and fall-through PC.
// Signed/unsigned compares are built only when BRANCH_EXT_EN is defined.
module b_target_gen
  import branch_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        cond,
  output logic [31:0] target,
  output logic [31:0] fall
);

  // Register addresses and opcode are consumed by the sequencer, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[6:0]};

  always_comb begin
    target = pc + b_imm(instr);
    fall   = pc + 32'(PC_STEP);
    cond   = 1'b0;
    case (instr[14:12])
      F3_BEQ:  cond = (rd1 == rd2);
      F3_BNE:  cond = (rd1 != rd2);
`ifdef BRANCH_EXT_EN
      F3_BLT:  cond = ($signed(rd1) <  $signed(rd2));
      F3_BGE:  cond = ($signed(rd1) >= $signed(rd2));
      F3_BLTU: cond = (rd1 <  rd2);
      F3_BGEU: cond = (rd1 >= rd2);
`endif
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Multicycle branch sequencer: accept, read RF operands, evaluate, strobe PC update.
// Define BRANCH_EXT_EN to accept BLT/BGE/BLTU/BGEU in addition to BEQ/BNE.
module branch_seq
  import branch_pkg::*;
#(
  parameter int unsigned RF_TIMEOUT = 15,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic        rf_req,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  input  logic        rf_ack,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        taken,
  output logic        err
);

  localparam int CNT_W = $clog2(RF_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rd1_q, rd1_d;
  logic [31:0]        rd2_q, rd2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               taken_q, taken_d;
  logic [31:0]        pc_next_q, pc_next_d;

  logic               cond;
  logic [31:0]        target;
  logic [31:0]        fall;

  function automatic logic f3_ok(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
`else
    return f3 inside {F3_BEQ, F3_BNE};
`endif
  endfunction

  b_target_gen #(
    .PC_STEP (PC_STEP)
  ) u_target_gen (
    .pc     (pc_q),
    .instr  (instr_q),
    .rd1    (rd1_q),
    .rd2    (rd2_q),
    .cond   (cond),
    .target (target),
    .fall   (fall)
  );

  always_comb begin
    // NOTE: every target gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    pc_next_d = pc_next_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (instr_valid) begin
          instr_d = instruction;
          pc_d    = pc;
          if (instruction[6:0] == OPC_BRANCH && f3_ok(instruction[14:12])) state_d = READ;
          else                                                            state_d = ERR;
        end
      end
      READ: begin
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (rf_ack) begin
          rd1_d   = rf_rd1;
          rd2_d   = rf_rd2;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(RF_TIMEOUT)) state_d = ERR;
        end
      end
      EXEC: begin
        taken_d   = cond;
        pc_next_d = cond ? target : fall;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign rf_req      = (state_q == READ);
  assign pc_we       = (state_q == DONE);
  assign err         = (state_q == ERR);
  assign rf_a1       = instr_q[19:15];
  assign rf_a2       = instr_q[24:20];
  assign taken       = taken_q;
  assign pc_next     = pc_next_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq with an expected-result scoreboard.
// Expectations follow BRANCH_EXT_EN when the bench is built with it.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic        rf_req;
  logic [4:0]  rf_a1;
  logic [4:0]  rf_a2;
  logic        rf_ack;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        taken;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          err;
    bit          taken;
    logic [31:0] pc_next;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc          (pc_in),
    .rf_req      (rf_req),
    .rf_a1       (rf_a1),
    .rf_a2       (rf_a2),
    .rf_ack      (rf_ack),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .pc_we       (pc_we),
    .pc_next     (pc_next),
    .taken       (taken),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  // Reference behaviour; imm is the intended offset, not re-decoded from the word.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input int imm, input int ack_cyc);
    exp_t        e;
    logic [2:0]  f3;
    bit          legal;
    bit          c;
    f3 = ins[14:12];
    e.err = 1'b0; e.taken = 1'b0; e.pc_next = '0; e.lat = 0; e.reqs = 0;
    legal = (ins[6:0] == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
`ifdef BRANCH_EXT_EN
    legal = legal || ((ins[6:0] == 7'b1100011) && f3[2]);
`endif
    if (!legal) begin
      e.err = 1'b1; e.lat = 1; e.reqs = 0;
      return e;
    end
    if (ack_cyc < 1 || ack_cyc > 15) begin
      e.err = 1'b1; e.lat = 16; e.reqs = 15;
      return e;
    end
    case (f3)
      3'b000:  c = (r1 == r2);
      3'b001:  c = (r1 != r2);
      3'b100:  c = ($signed(r1) <  $signed(r2));
      3'b101:  c = ($signed(r1) >= $signed(r2));
      3'b110:  c = (r1 <  r2);
      3'b111:  c = (r1 >= r2);
      default: c = 1'b0;
    endcase
    e.taken   = c;
    e.pc_next = c ? p + 32'(imm) : p + 32'd4;
    e.lat     = ack_cyc + 2;
    e.reqs    = ack_cyc;
    return e;
  endfunction

  // Starts at a falling edge with the DUT idle; ack_cyc counts READ cycles from 1 (0 = never).
  task automatic run(input string name, input logic [31:0] ins, input logic [31:0] p,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input int imm, input int ack_cyc);
    exp_t e;
    bit   done;
    bit   got_err;
    bit   got_taken;
    logic [31:0] got_pc;
    int   got_lat;
    int   reqs;
    sb.push_back(model(ins, p, r1, r2, imm, ack_cyc));
    check({name, "_ready"}, 32'(instr_ready), 32'd1);
    instruction = ins;
    pc_in       = p;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = $urandom();
    pc_in       = $urandom();
    done = 1'b0; reqs = 0; got_lat = 0; got_err = 1'b0; got_taken = 1'b0; got_pc = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (pc_we || err) begin
        done      = 1'b1;
        got_err   = err;
        got_taken = taken;
        got_pc    = pc_next;
        got_lat   = cyc;
      end else begin
        if (rf_req) begin
          reqs++;
          if (reqs == 1) begin
            check({name, "_rf_a1"}, 32'(rf_a1), 32'(ins[19:15]));
            check({name, "_rf_a2"}, 32'(rf_a2), 32'(ins[24:20]));
          end
        end
        rf_ack = (cyc == ack_cyc);
        rf_rd1 = (cyc == ack_cyc) ? r1 : $urandom();
        rf_rd2 = (cyc == ack_cyc) ? r2 : $urandom();
        @(negedge clk);
      end
    end
    rf_ack = 1'b0;
    e = sb.pop_front();
    check({name, "_completed"}, 32'(done), 32'd1);
    if (done) begin
      check({name, "_err"},     32'(got_err), 32'(e.err));
      check({name, "_latency"}, 32'(got_lat), 32'(e.lat));
      check({name, "_rf_reqs"}, 32'(reqs),    32'(e.reqs));
      if (!e.err) begin
        check({name, "_taken"},   32'(got_taken), 32'(e.taken));
        check({name, "_pc_next"}, got_pc,         e.pc_next);
      end
      @(negedge clk);
      check({name, "_pulse_pc_we"}, 32'(pc_we),       32'd0);
      check({name, "_pulse_err"},   32'(err),         32'd0);
      check({name, "_idle_ready"},  32'(instr_ready), 32'd1);
      if (!e.err) check({name, "_pc_next_hold"}, pc_next, e.pc_next);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    rst = 1'b1; instr_valid = 1'b0; instruction = '0; pc_in = '0;
    rf_ack = 1'b0; rf_rd1 = '0; rf_rd2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",   32'(instr_ready), 32'd1);
    check("rst_rf_req",  32'(rf_req),      32'd0);
    check("rst_pc_we",   32'(pc_we),       32'd0);
    check("rst_taken",   32'(taken),       32'd0);
    check("rst_err",     32'(err),         32'd0);
    check("rst_pc_next", pc_next,          32'd0);
    check("rst_rf_a1",   32'(rf_a1),       32'd0);
    check("rst_rf_a2",   32'(rf_a2),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("beq_p8",      enc_b(8, 5'd2, 5'd1, 3'b000),  32'h100, 32'd5, 32'd5, 8, 1);
    run("bne_m4_eq",   enc_b(-4, 5'd4, 5'd3, 3'b001), 32'h200, 32'd7, 32'd7, -4, 1);
    run("bne_m4_ne",   enc_b(-4, 5'd4, 5'd3, 3'b001), 32'h200, 32'd7, 32'd8, -4, 3);
    run("beq_wrap",    enc_b(-4096, 5'd9, 5'd8, 3'b000), 32'h10, 32'hA5, 32'hA5, -4096, 2);
    run("beq_max_imm", enc_b(4094, 5'd31, 5'd30, 3'b000), 32'hFFFF_F800, 32'd1, 32'd1, 4094, 1);
    run("bad_opcode",  32'h0020_81B3, 32'h300, 32'd0, 32'd0, 0, 1);
    run("bad_f3_010",  enc_b(8, 5'd2, 5'd1, 3'b010), 32'h300, 32'd0, 32'd0, 8, 1);
    run("rf_timeout",  enc_b(8, 5'd2, 5'd1, 3'b000), 32'h400, 32'd1, 32'd1, 8, 0);
    run("ack_at_15",   enc_b(16, 5'd2, 5'd1, 3'b000), 32'h400, 32'd3, 32'd3, 16, 15);
    run("blt_signed",  enc_b(12, 5'd2, 5'd1, 3'b100), 32'h500, 32'hFFFF_FFFF, 32'd1, 12, 1);
    run("bltu_unsgn",  enc_b(12, 5'd2, 5'd1, 3'b110), 32'h500, 32'hFFFF_FFFF, 32'd1, 12, 1);
    run("bgeu_unsgn",  enc_b(-32, 5'd2, 5'd1, 3'b111), 32'h500, 32'hFFFF_FFFF, 32'd1, -32, 2);

    // Reset while waiting in READ aborts the branch without a PC write.
    instruction = enc_b(8, 5'd2, 5'd1, 3'b000);
    pc_in       = 32'h600;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_read", 32'(rf_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rf_req", 32'(rf_req),      32'd0);
    check("mid_rst_ready",  32'(instr_ready), 32'd1);
    check("mid_rst_pc_we",  32'(pc_we),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pc_we || rf_req) we_seen++;
    end
    check("mid_rst_quiet", 32'(we_seen), 32'd0);
    run("after_rst", enc_b(20, 5'd6, 5'd5, 3'b001), 32'h700, 32'd1, 32'd2, 20, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
